// File: rtl/rr_fifo_arbiter.sv
// rr_fifo_arbiter
// Round-robin write arbiter that shares one FIFO write port between
// NUM_WRITERS writers. Each writer has its own 8-bit lane. At most one
// writer is granted per cycle. The chosen byte is registered onto o_data
// together with o_we, and the served writer gets a one-cycle o_ack.
//
// Ports
//   i_clk              single clock, rising edge
//   i_reset            synchronous, active-high reset
//   i_req              per-writer request
//   i_data             lane k = i_data[8k+7:8k]
//   i_fifo_full        FIFO cannot accept a write at this edge
//   i_fifo_almost_full FIFO has exactly one free slot
//   o_ack              one-hot (or zero) acknowledge of the byte being written
//   o_we               registered FIFO write enable
//   o_data             registered FIFO write data
//   o_grant_id         index of the writer being served
module rr_fifo_arbiter #(
    parameter int NUM_WRITERS = 4,
    parameter int ID_W        = $clog2(NUM_WRITERS)
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NUM_WRITERS-1:0]   i_req,
    input  logic [8*NUM_WRITERS-1:0] i_data,
    input  logic                     i_fifo_full,
    input  logic                     i_fifo_almost_full,
    output logic [NUM_WRITERS-1:0]   o_ack,
    output logic                     o_we,
    output logic [7:0]               o_data,
    output logic [ID_W-1:0]          o_grant_id
);

    logic [NUM_WRITERS-1:0] ack_q, ack_d;
    logic                   we_q, we_d;
    logic [7:0]             data_q, data_d;
    logic [ID_W-1:0]        gid_q, gid_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;

    logic                   space_ok;
    logic [NUM_WRITERS-1:0] elig;
    logic                   grant;
    logic [ID_W-1:0]        sel;
    logic [ID_W:0]          idx;

    // The write currently on the bus consumes the last free slot when the
    // FIFO reports almost-full, so no new grant is allowed in that case.
    assign space_ok = !i_fifo_full && !(we_q && i_fifo_almost_full);

    // A writer that is being acked this cycle still shows its old byte, so it
    // is masked until the next edge.
    assign elig = i_req & ~ack_q & {NUM_WRITERS{space_ok}};

    // First eligible writer starting at ptr, wrapping at NUM_WRITERS.
    always_comb begin
        grant = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_WRITERS; i++) begin
            idx = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(NUM_WRITERS)) begin
                idx = idx - (ID_W+1)'(NUM_WRITERS);
            end
            if (!grant && elig[idx[ID_W-1:0]]) begin
                grant = 1'b1;
                sel   = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        we_d   = grant;
        ack_d  = '0;
        data_d = data_q;
        gid_d  = gid_q;
        ptr_d  = ptr_q;
        if (grant) begin
            ack_d[sel] = 1'b1;
            data_d     = i_data[8*sel +: 8];
            gid_d      = sel;
            ptr_d      = (sel == ID_W'(NUM_WRITERS-1)) ? '0 : sel + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            we_q   <= 1'b0;
            ack_q  <= '0;
            data_q <= 8'h00;
            gid_q  <= '0;
            ptr_q  <= '0;
        end else begin
            we_q   <= we_d;
            ack_q  <= ack_d;
            data_q <= data_d;
            gid_q  <= gid_d;
            ptr_q  <= ptr_d;
        end
    end

    assign o_ack      = ack_q;
    assign o_we       = we_q;
    assign o_data     = data_q;
    assign o_grant_id = gid_q;

endmodule

// File: tb/tb_rr_fifo_arbiter.sv
// tb_rr_fifo_arbiter
// Directed scenarios followed by randomized traffic. A behavioural model
// predicts o_we/o_ack/o_data/o_grant_id for every cycle. The model keeps the
// round-robin pointer as an integer and does the search with modulo
// arithmetic.
module tb_rr_fifo_arbiter;

    localparam int N    = 4;
    localparam int ID_W = $clog2(N);

    logic                 i_clk = 1'b0;
    logic                 i_reset;
    logic [N-1:0]         i_req;
    logic [8*N-1:0]       i_data;
    logic                 i_fifo_full;
    logic                 i_fifo_almost_full;
    logic [N-1:0]         o_ack;
    logic                 o_we;
    logic [7:0]           o_data;
    logic [ID_W-1:0]      o_grant_id;

    logic [7:0]           lane [N];

    int n_cmp = 0;
    int n_err = 0;

    // model state: outputs expected after the most recent edge
    int m_we, m_gid, m_data, m_ptr;

    always #5 i_clk = ~i_clk;

    always_comb begin
        i_data = '0;
        for (int k = 0; k < N; k++) i_data[8*k +: 8] = lane[k];
    end

    rr_fifo_arbiter #(.NUM_WRITERS(N)) dut (
        .i_clk              (i_clk),
        .i_reset            (i_reset),
        .i_req              (i_req),
        .i_data             (i_data),
        .i_fifo_full        (i_fifo_full),
        .i_fifo_almost_full (i_fifo_almost_full),
        .o_ack              (o_ack),
        .o_we               (o_we),
        .o_data             (o_data),
        .o_grant_id         (o_grant_id)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock: predict from the inputs now applied, let the edge
    // happen, then compare at the following negedge.
    task automatic step();
        int n_we, n_gid, n_data, n_ptr;
        bit space;
        int k;
        if (i_reset) begin
            n_we = 0; n_gid = 0; n_data = 0; n_ptr = 0;
        end else begin
            space  = !i_fifo_full && !(m_we != 0 && i_fifo_almost_full);
            n_we   = 0;
            n_gid  = m_gid;
            n_data = m_data;
            n_ptr  = m_ptr;
            if (space) begin
                for (int i = 0; i < N; i++) begin
                    k = (m_ptr + i) % N;
                    if (n_we == 0 && i_req[k] && !(m_we != 0 && m_gid == k)) begin
                        n_we   = 1;
                        n_gid  = k;
                        n_data = int'(lane[k]);
                        n_ptr  = (k + 1) % N;
                    end
                end
            end
        end
        @(posedge i_clk);
        @(negedge i_clk);
        m_we = n_we; m_gid = n_gid; m_data = n_data; m_ptr = n_ptr;
        chk("we",   32'(o_we),       32'(m_we));
        chk("ack",  32'(o_ack),      (m_we != 0) ? (32'd1 << m_gid) : 32'd0);
        chk("data", 32'(o_data),     32'(m_data));
        chk("gid",  32'(o_grant_id), 32'(m_gid));
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
    endtask

    initial begin
        int w2_cnt;
        i_reset = 1'b1;
        i_req = '0;
        i_fifo_full = 1'b0;
        i_fifo_almost_full = 1'b0;
        for (int k = 0; k < N; k++) lane[k] = 8'h00;
        m_we = 0; m_gid = 0; m_data = 0; m_ptr = 0;
        @(negedge i_clk);

        // reset and idle
        do_reset();
        chk("rst_we",   32'(o_we),       32'd0);
        chk("rst_data", 32'(o_data),     32'd0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("idle_we",  32'(o_we),       32'd0);
            chk("idle_ack", 32'(o_ack),      32'd0);
            chk("idle_gid", 32'(o_grant_id), 32'd0);
        end

        // all writers streaming
        for (int k = 0; k < N; k++) lane[k] = 8'hA0 + 8'(k);
        i_req = '1;
        for (int c = 0; c < 12; c++) begin
            step();
            chk("rr_seq", 32'(o_data), 32'(8'hA0 + 8'(c % 4)));
            chk("rr_gid", 32'(o_grant_id), 32'(c % 4));
        end

        // reset while streaming
        do_reset();
        chk("mid_rst_we",  32'(o_we),  32'd0);
        chk("mid_rst_ack", 32'(o_ack), 32'd0);
        step();
        chk("post_rst_gid", 32'(o_grant_id), 32'd0);
        chk("post_rst_we",  32'(o_we),       32'd1);

        // single writer 2 with updating bytes
        i_req = '0;
        do_reset();
        lane[2] = 8'h10;
        i_req = 4'b0100;
        w2_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (o_we && o_grant_id == 2) begin
                chk("w2_byte", 32'(o_data), 32'(8'h10 + 8'(w2_cnt)));
                w2_cnt++;
            end
            if (m_we != 0 && m_gid == 2) begin
                if (lane[2] == 8'h12) i_req[2] = 1'b0;
                else lane[2] = lane[2] + 8'd1;
            end
        end
        chk("w2_cnt", 32'(w2_cnt), 32'd3);

        // backpressure
        i_req = '0;
        do_reset();
        lane[0] = 8'h40; lane[1] = 8'h41;
        i_req = 4'b0011;
        step();
        chk("bp_first", 32'(o_grant_id), 32'd0);
        i_fifo_almost_full = 1'b1;
        step();
        chk("bp_af_we", 32'(o_we), 32'd0);
        i_fifo_almost_full = 1'b0;
        i_fifo_full = 1'b1;
        step();
        step();
        chk("bp_full_we", 32'(o_we), 32'd0);
        i_fifo_full = 1'b0;
        step();
        chk("bp_resume", 32'(o_grant_id), 32'd1);
        step();
        chk("bp_next", 32'(o_grant_id), 32'd0);

        // pointer wrap from writer 3
        i_req = '0;
        do_reset();
        lane[3] = 8'h33;
        i_req = 4'b1000;
        step();
        chk("wrap_w3", 32'(o_grant_id), 32'd3);
        i_req = 4'b1001;
        step();
        chk("wrap_w0", 32'(o_grant_id), 32'd0);
        step();
        chk("wrap_w3b", 32'(o_grant_id), 32'd3);

        // randomized traffic, writers follow the hold-until-ack protocol
        i_req = '0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++) begin
                if (m_we != 0 && m_gid == k) begin
                    if ($urandom_range(0, 1) == 0) i_req[k] = 1'b0;
                    else lane[k] = 8'($urandom_range(0, 255));
                end else if (!i_req[k] && $urandom_range(0, 2) == 0) begin
                    i_req[k] = 1'b1;
                    lane[k]  = 8'($urandom_range(0, 255));
                end
            end
            i_fifo_full        = ($urandom_range(0, 7) == 0);
            i_fifo_almost_full = ($urandom_range(0, 3) == 0);
            i_reset            = ($urandom_range(0, 127) == 0);
            step();
        end
        i_reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
